// File: rtl/flag_pkg.sv
// Shared types for the flag unit: branch-condition codes, FSM state and code width.
package flag_pkg;

  localparam int unsigned BR_W = 3;

  typedef enum logic [BR_W-1:0] {
    BRN  = BR_W'(0),
    BREQ = BR_W'(1),
    BRNE = BR_W'(2),
    BRCS = BR_W'(3),
    BRCC = BR_W'(4)
  } br_cond_e;

  typedef enum logic {
    NORMAL = 1'b0,
    ISR    = 1'b1
  } state_e;

endpackage

// File: rtl/flag_unit_flag_bit.sv
// One-bit loadable register used for every live and shadow flag.
module flag_bit (
  input  logic CLK,
  input  logic RST,
  input  logic LD,
  input  logic D,
  output logic Q
);

  always_ff @(posedge CLK) begin
    if (RST) begin
      Q <= 1'b0;
    end else if (LD) begin
      Q <= D;
    end
  end

endmodule

// File: rtl/flag_unit.sv
// Carry/zero flag unit with single-level interrupt shadowing and a registered
// branch-condition evaluator.
module flag_unit
  import flag_pkg::*;
#(
  parameter int unsigned BR_W = flag_pkg::BR_W
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            C_IN,
  input  logic            Z_IN,
  input  logic            C_LD,
  input  logic            Z_LD,
  input  logic            C_SET,
  input  logic            C_CLR,
  input  logic            SHAD_SAVE,
  input  logic            SHAD_RESTORE,
  input  logic            BR_REQ,
  input  logic [BR_W-1:0] BR_COND,
  output logic            C_FLAG,
  output logic            Z_FLAG,
  output logic            BR_VALID,
  output logic            BR_TAKEN,
  output logic            IN_ISR
);

  localparam logic ST_NORMAL = NORMAL;
  localparam logic ST_ISR    = ISR;

  logic state_q;
  logic state_d;
  logic save_ok;
  logic restore_ok;
  logic c_ld;
  logic c_d;
  logic z_ld;
  logic z_d;
  logic shad_c;
  logic shad_z;
  logic br_hit;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_NORMAL;
    end else begin
      state_q <= state_d;
    end
  end

  // Save is only legal from NORMAL and restore only from ISR, so a
  // simultaneous save+restore resolves to whichever the state allows.
  always_comb begin
    state_d    = state_q;
    save_ok    = 1'b0;
    restore_ok = 1'b0;
    c_ld       = 1'b0;
    c_d        = 1'b0;
    z_ld       = 1'b0;
    z_d        = 1'b0;

    case (state_q)
      ST_NORMAL: begin
        if (SHAD_SAVE) begin
          save_ok = 1'b1;
          state_d = ST_ISR;
        end
      end
      ST_ISR: begin
        if (SHAD_RESTORE) begin
          restore_ok = 1'b1;
          state_d    = ST_NORMAL;
        end
      end
      default: state_d = ST_NORMAL;
    endcase

    if (restore_ok) begin
      c_ld = 1'b1;
      c_d  = shad_c;
    end else if (C_SET) begin
      c_ld = 1'b1;
      c_d  = 1'b1;
    end else if (C_CLR) begin
      c_ld = 1'b1;
      c_d  = 1'b0;
    end else if (C_LD) begin
      c_ld = 1'b1;
      c_d  = C_IN;
    end

    if (restore_ok) begin
      z_ld = 1'b1;
      z_d  = shad_z;
    end else if (Z_LD) begin
      z_ld = 1'b1;
      z_d  = Z_IN;
    end
  end

  flag_bit u_c (.CLK(CLK), .RST(RST), .LD(c_ld), .D(c_d), .Q(C_FLAG));
  flag_bit u_z (.CLK(CLK), .RST(RST), .LD(z_ld), .D(z_d), .Q(Z_FLAG));

  // Shadows capture the pre-edge live flags, even if those change on the same edge.
  flag_bit u_shad_c (.CLK(CLK), .RST(RST), .LD(save_ok), .D(C_FLAG), .Q(shad_c));
  flag_bit u_shad_z (.CLK(CLK), .RST(RST), .LD(save_ok), .D(Z_FLAG), .Q(shad_z));

  always_comb begin
    br_hit = 1'b0;
    case (BR_COND)
      BR_W'(BRN):  br_hit = 1'b1;
      BR_W'(BREQ): br_hit = Z_FLAG;
      BR_W'(BRNE): br_hit = ~Z_FLAG;
      BR_W'(BRCS): br_hit = C_FLAG;
      BR_W'(BRCC): br_hit = ~C_FLAG;
      default:     br_hit = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      BR_VALID <= 1'b0;
      BR_TAKEN <= 1'b0;
    end else begin
      BR_VALID <= BR_REQ;
      BR_TAKEN <= BR_REQ & br_hit;
    end
  end

  assign IN_ISR = (state_q == ST_ISR);

endmodule

// File: tb/tb_flag_unit.sv
// Self-checking bench for flag_unit: directed scenarios plus random stimulus
// against a behavioural flag/shadow/branch model.
module tb_flag_unit;

  localparam int unsigned BR_W = 3;

  logic            CLK = 1'b0;
  logic            RST;
  logic            C_IN, Z_IN, C_LD, Z_LD, C_SET, C_CLR;
  logic            SHAD_SAVE, SHAD_RESTORE, BR_REQ;
  logic [BR_W-1:0] BR_COND;
  logic            C_FLAG, Z_FLAG, BR_VALID, BR_TAKEN, IN_ISR;

  int errors = 0;
  int checks = 0;

  bit m_c, m_z, m_sc, m_sz, m_isr, m_bv, m_bt;

  flag_unit #(.BR_W(BR_W)) dut (
    .CLK(CLK), .RST(RST), .C_IN(C_IN), .Z_IN(Z_IN), .C_LD(C_LD), .Z_LD(Z_LD),
    .C_SET(C_SET), .C_CLR(C_CLR), .SHAD_SAVE(SHAD_SAVE), .SHAD_RESTORE(SHAD_RESTORE),
    .BR_REQ(BR_REQ), .BR_COND(BR_COND), .C_FLAG(C_FLAG), .Z_FLAG(Z_FLAG),
    .BR_VALID(BR_VALID), .BR_TAKEN(BR_TAKEN), .IN_ISR(IN_ISR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit br_rule(input int cond, input bit c, input bit z);
    case (cond)
      0: return 1'b1;
      1: return z;
      2: return !z;
      3: return c;
      4: return !c;
      default: return 1'b0;
    endcase
  endfunction

  task automatic idle();
    RST = 1'b0; C_IN = 1'b0; Z_IN = 1'b0; C_LD = 1'b0; Z_LD = 1'b0;
    C_SET = 1'b0; C_CLR = 1'b0; SHAD_SAVE = 1'b0; SHAD_RESTORE = 1'b0;
    BR_REQ = 1'b0; BR_COND = '0;
  endtask

  // Advance one clock; model the edge from the inputs held across it, then compare.
  task automatic tick();
    bit nc, nz, nsc, nsz, nisr, nbv, nbt;
    if (RST) begin
      {nc, nz, nsc, nsz, nisr, nbv, nbt} = '0;
    end else begin
      nc = m_c; nz = m_z; nsc = m_sc; nsz = m_sz; nisr = m_isr;
      nbv = BR_REQ;
      nbt = BR_REQ && br_rule(int'(BR_COND), m_c, m_z);
      if (!m_isr && SHAD_SAVE) begin
        nsc = m_c; nsz = m_z; nisr = 1'b1;
      end else if (m_isr && SHAD_RESTORE) begin
        nisr = 1'b0;
      end
      if (m_isr && SHAD_RESTORE) nc = m_sc;
      else if (C_SET)            nc = 1'b1;
      else if (C_CLR)            nc = 1'b0;
      else if (C_LD)             nc = C_IN;
      if (m_isr && SHAD_RESTORE) nz = m_sz;
      else if (Z_LD)             nz = Z_IN;
    end
    @(posedge CLK);
    #1;
    m_c = nc; m_z = nz; m_sc = nsc; m_sz = nsz; m_isr = nisr; m_bv = nbv; m_bt = nbt;
    chk("c_flag", C_FLAG, m_c);
    chk("z_flag", Z_FLAG, m_z);
    chk("in_isr", IN_ISR, m_isr);
    chk("br_valid", BR_VALID, m_bv);
    chk("br_taken", BR_TAKEN, m_bt);
  endtask

  task automatic rand_inputs(input int rst_odds);
    RST          = ($urandom_range(0, rst_odds - 1) == 0);
    C_IN         = 1'($urandom);
    Z_IN         = 1'($urandom);
    C_LD         = 1'($urandom);
    Z_LD         = 1'($urandom);
    C_SET        = ($urandom_range(0, 3) == 0);
    C_CLR        = ($urandom_range(0, 3) == 0);
    SHAD_SAVE    = ($urandom_range(0, 3) == 0);
    SHAD_RESTORE = ($urandom_range(0, 3) == 0);
    BR_REQ       = 1'($urandom);
    BR_COND      = BR_W'($urandom_range(0, 7));
  endtask

  initial begin
    bit exp_taken [6];
    exp_taken = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    idle();
    RST = 1'b1;
    tick();
    tick();

    // Arbitrary activity, then a two-cycle reset.
    for (int i = 0; i < 20; i++) begin
      rand_inputs(1000);
      RST = 1'b0;
      tick();
    end
    idle();
    RST = 1'b1;
    tick();
    tick();
    chk("rst_c", C_FLAG, 1'b0);
    chk("rst_z", Z_FLAG, 1'b0);
    chk("rst_valid", BR_VALID, 1'b0);
    chk("rst_taken", BR_TAKEN, 1'b0);
    chk("rst_isr", IN_ISR, 1'b0);

    // C_SET beats C_CLR and C_LD.
    idle();
    C_SET = 1'b1; C_CLR = 1'b1; C_LD = 1'b1; C_IN = 1'b0;
    tick();
    chk("prio_c", C_FLAG, 1'b1);

    // Save C=1,Z=0, scribble in the ISR, nested save ignored, restore.
    idle();
    C_SET = 1'b1; Z_LD = 1'b1; Z_IN = 1'b0;
    tick();
    idle();
    SHAD_SAVE = 1'b1;
    tick();
    chk("save_isr", IN_ISR, 1'b1);
    idle();
    C_CLR = 1'b1; Z_LD = 1'b1; Z_IN = 1'b1;
    tick();
    chk("isr_c", C_FLAG, 1'b0);
    chk("isr_z", Z_FLAG, 1'b1);
    idle();
    SHAD_SAVE = 1'b1;
    tick();
    chk("nest_isr", IN_ISR, 1'b1);
    idle();
    SHAD_RESTORE = 1'b1;
    tick();
    chk("restore_c", C_FLAG, 1'b1);
    chk("restore_z", Z_FLAG, 1'b0);
    chk("restore_isr", IN_ISR, 1'b0);
    tick();
    chk("stray_restore_c", C_FLAG, 1'b1);
    chk("stray_restore_z", Z_FLAG, 1'b0);
    chk("stray_restore_isr", IN_ISR, 1'b0);

    // Branch codes 0..5 back to back with Z=1, C=0.
    idle();
    C_CLR = 1'b1; Z_LD = 1'b1; Z_IN = 1'b1;
    tick();
    idle();
    for (int i = 0; i < 6; i++) begin
      BR_REQ = 1'b1;
      BR_COND = BR_W'(i);
      tick();
      chk("br_seq_valid", BR_VALID, 1'b1);
      chk("br_seq_taken", BR_TAKEN, exp_taken[i]);
    end
    idle();
    tick();
    chk("br_idle_valid", BR_VALID, 1'b0);
    chk("br_idle_taken", BR_TAKEN, 1'b0);

    // BREQ sees the pre-edge Z while Z_LD updates it on the same edge.
    Z_LD = 1'b1; Z_IN = 1'b0;
    tick();
    idle();
    BR_REQ = 1'b1; BR_COND = BR_W'(1); Z_LD = 1'b1; Z_IN = 1'b1;
    tick();
    chk("coinc_taken", BR_TAKEN, 1'b0);
    chk("coinc_z", Z_FLAG, 1'b1);

    // Save with a coincident load: live flag moves, shadow keeps old value.
    idle();
    SHAD_SAVE = 1'b1; C_LD = 1'b1; C_IN = 1'b1;
    tick();
    chk("save_ld_c", C_FLAG, 1'b1);
    idle();
    SHAD_RESTORE = 1'b1; SHAD_SAVE = 1'b1;
    tick();
    chk("save_ld_restore_c", C_FLAG, 1'b0);
    chk("both_isr", IN_ISR, 1'b0);

    // Reset beats a request and a save in flight.
    idle();
    RST = 1'b1; BR_REQ = 1'b1; SHAD_SAVE = 1'b1; C_SET = 1'b1;
    tick();
    idle();
    tick();
    chk("rst_req_valid", BR_VALID, 1'b0);
    chk("rst_req_isr", IN_ISR, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      rand_inputs(64);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
